// File: rtl/cluster_speriph_plug_arb.sv
// Round-robin arbiter that merges NB_PLUGS peripheral-bus plugs onto one target.
// Responses are routed back in order through a FIFO of granted plug indices.
module cluster_speriph_plug_arb #(
    parameter int unsigned NB_PLUGS   = 2,
    parameter int unsigned ID_WIDTH   = 9,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_PLUGS-1:0]                s_req_i,
    input  logic [NB_PLUGS-1:0][31:0]          s_add_i,
    input  logic [NB_PLUGS-1:0]                s_wen_i,
    input  logic [NB_PLUGS-1:0][31:0]          s_wdata_i,
    input  logic [NB_PLUGS-1:0][3:0]           s_be_i,
    input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  s_id_i,
    output logic [NB_PLUGS-1:0]                s_gnt_o,
    output logic [NB_PLUGS-1:0]                s_r_valid_o,
    output logic [31:0]                        s_r_rdata_o,
    output logic                               s_r_opc_o,
    output logic [ID_WIDTH-1:0]                s_r_id_o,
    output logic                               m_req_o,
    output logic [31:0]                        m_add_o,
    output logic                               m_wen_o,
    output logic [31:0]                        m_wdata_o,
    output logic [3:0]                         m_be_o,
    output logic [ID_WIDTH-1:0]                m_id_o,
    input  logic                               m_gnt_i,
    input  logic                               m_r_valid_i,
    input  logic [31:0]                        m_r_rdata_i,
    input  logic                               m_r_opc_i,
    input  logic [ID_WIDTH-1:0]                m_r_id_i,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int unsigned PW = $clog2(NB_PLUGS);
    localparam int unsigned AW = $clog2(RESP_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PW-1:0]                  rr_q, rr_d;
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic                           err_q, err_d;
    logic [RESP_DEPTH-1:0][PW-1:0]  fifo_q, fifo_d;

    logic [PW-1:0]                  winner;
    logic [PW-1:0]                  cand;
    logic [PW:0]                    sum;
    logic                           found;
    logic                           full;
    logic                           push;
    logic                           pop;
    logic                           drop;

    // First requesting plug at or above the priority pointer, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        sum    = '0;
        for (int unsigned k = 0; k < NB_PLUGS; k++) begin
            sum = {1'b0, rr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NB_PLUGS)) begin
                sum = sum - (PW+1)'(NB_PLUGS);
            end
            cand = PW'(sum);
            if (!found && s_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Request path is a zero-latency mux of the winner's fields.
    assign full      = (count_q == CW'(RESP_DEPTH));
    assign m_req_o   = (|s_req_i) & ~full;
    assign m_add_o   = s_add_i[winner];
    assign m_wen_o   = s_wen_i[winner];
    assign m_wdata_o = s_wdata_i[winner];
    assign m_be_o    = s_be_i[winner];
    assign m_id_o    = s_id_i[winner];

    assign push = m_req_o & m_gnt_i;
    assign pop  = m_r_valid_i & (count_q != '0);
    assign drop = m_r_valid_i & (count_q == '0);

    // Response payload is shared and passed through unqualified.
    assign s_r_rdata_o = m_r_rdata_i;
    assign s_r_opc_o   = m_r_opc_i;
    assign s_r_id_o    = m_r_id_i;

    assign busy_o = (count_q != '0);
    assign err_o  = err_q;

    // Grant/response decode and next-state for pointer, FIFO and error flag.
    always_comb begin
        rr_d        = rr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_d      = fifo_q;
        err_d       = err_q | drop;
        s_gnt_o     = '0;
        s_r_valid_o = '0;
        count_d     = count_q + CW'(push) - CW'(pop);
        if (push) begin
            s_gnt_o[winner]  = 1'b1;
            fifo_d[wr_ptr_q] = winner;
            wr_ptr_d         = wr_ptr_q + AW'(1);
            rr_d             = (winner == PW'(NB_PLUGS - 1)) ? '0 : winner + PW'(1);
        end
        if (pop) begin
            s_r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
            rd_ptr_d                      = rd_ptr_q + AW'(1);
        end
    end

    // State registers; reset discards all outstanding entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            fifo_q   <= '0;
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_cluster_speriph_plug_arb.sv
// Directed and randomized bench for cluster_speriph_plug_arb against a queue-based model.
module tb_cluster_speriph_plug_arb;

    localparam int NB    = 4;
    localparam int IDW   = 9;
    localparam int DEPTH = 4;

    logic                    clk;
    logic                    rst_n;
    logic [NB-1:0]           s_req_i;
    logic [NB-1:0][31:0]     s_add_i;
    logic [NB-1:0]           s_wen_i;
    logic [NB-1:0][31:0]     s_wdata_i;
    logic [NB-1:0][3:0]      s_be_i;
    logic [NB-1:0][IDW-1:0]  s_id_i;
    logic [NB-1:0]           s_gnt_o;
    logic [NB-1:0]           s_r_valid_o;
    logic [31:0]             s_r_rdata_o;
    logic                    s_r_opc_o;
    logic [IDW-1:0]          s_r_id_o;
    logic                    m_req_o;
    logic [31:0]             m_add_o;
    logic                    m_wen_o;
    logic [31:0]             m_wdata_o;
    logic [3:0]              m_be_o;
    logic [IDW-1:0]          m_id_o;
    logic                    m_gnt_i;
    logic                    m_r_valid_i;
    logic [31:0]             m_r_rdata_i;
    logic                    m_r_opc_i;
    logic [IDW-1:0]          m_r_id_i;
    logic                    busy_o;
    logic                    err_o;

    cluster_speriph_plug_arb #(
        .NB_PLUGS  (NB),
        .ID_WIDTH  (IDW),
        .RESP_DEPTH(DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_req_i     (s_req_i),
        .s_add_i     (s_add_i),
        .s_wen_i     (s_wen_i),
        .s_wdata_i   (s_wdata_i),
        .s_be_i      (s_be_i),
        .s_id_i      (s_id_i),
        .s_gnt_o     (s_gnt_o),
        .s_r_valid_o (s_r_valid_o),
        .s_r_rdata_o (s_r_rdata_o),
        .s_r_opc_o   (s_r_opc_o),
        .s_r_id_o    (s_r_id_o),
        .m_req_o     (m_req_o),
        .m_add_o     (m_add_o),
        .m_wen_o     (m_wen_o),
        .m_wdata_o   (m_wdata_o),
        .m_be_o      (m_be_o),
        .m_id_o      (m_id_o),
        .m_gnt_i     (m_gnt_i),
        .m_r_valid_i (m_r_valid_i),
        .m_r_rdata_i (m_r_rdata_i),
        .m_r_opc_i   (m_r_opc_i),
        .m_r_id_i    (m_r_id_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: priority pointer, in-order queue of plug indices, sticky error.
    int rr_m;
    int q_m[$];
    bit err_m;

    // Per-cycle predictions consumed by advance().
    bit p_push, p_pop, p_drop;
    int p_win;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [NB-1:0] req, input int rr);
        for (int k = 0; k < NB; k++) begin
            if (req[(rr + k) % NB]) return (rr + k) % NB;
        end
        return -1;
    endfunction

    task automatic model_reset();
        rr_m  = 0;
        q_m.delete();
        err_m = 1'b0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NB; i++) begin
            s_add_i[i]   = $urandom;
            s_wen_i[i]   = 1'($urandom);
            s_wdata_i[i] = $urandom;
            s_be_i[i]    = 4'($urandom);
            s_id_i[i]    = IDW'($urandom);
        end
        m_r_rdata_i = $urandom;
        m_r_opc_i   = 1'($urandom);
        m_r_id_i    = IDW'($urandom);
    endtask

    // Mid-cycle comparison of every output against the model.
    task automatic check_outputs();
        int w;
        bit full, ereq;
        logic [NB-1:0] exp_gnt, exp_rv;
        #4;
        full   = (q_m.size() == DEPTH);
        w      = model_winner(s_req_i, rr_m);
        ereq   = (w >= 0) && !full;
        p_push = ereq && m_gnt_i;
        p_win  = w;
        p_pop  = m_r_valid_i && (q_m.size() > 0);
        p_drop = m_r_valid_i && (q_m.size() == 0);
        exp_gnt = '0;
        exp_rv  = '0;
        if (p_push) exp_gnt[w] = 1'b1;
        if (p_pop) exp_rv[q_m[0]] = 1'b1;
        chk("m_req", 64'(m_req_o), 64'(ereq));
        chk("s_gnt", 64'(s_gnt_o), 64'(exp_gnt));
        chk("s_r_valid", 64'(s_r_valid_o), 64'(exp_rv));
        chk("busy", 64'(busy_o), 64'(q_m.size() != 0));
        chk("err", 64'(err_o), 64'(err_m));
        chk("r_rdata", 64'(s_r_rdata_o), 64'(m_r_rdata_i));
        chk("r_opc", 64'(s_r_opc_o), 64'(m_r_opc_i));
        chk("r_id", 64'(s_r_id_o), 64'(m_r_id_i));
        if (ereq) begin
            chk("m_add", 64'(m_add_o), 64'(s_add_i[w]));
            chk("m_wen", 64'(m_wen_o), 64'(s_wen_i[w]));
            chk("m_wdata", 64'(m_wdata_o), 64'(s_wdata_i[w]));
            chk("m_be", 64'(m_be_o), 64'(s_be_i[w]));
            chk("m_id", 64'(m_id_o), 64'(s_id_i[w]));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (p_pop) void'(q_m.pop_front());
        if (p_push) begin
            q_m.push_back(p_win);
            rr_m = (p_win + 1) % NB;
        end
        if (p_drop) err_m = 1'b1;
        #1;
    endtask

    task automatic step();
        check_outputs();
        advance();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        s_req_i     = '0;
        m_gnt_i     = 1'b0;
        m_r_valid_i = 1'b0;
        #2;
        model_reset();
        chk("rst_gnt", 64'(s_gnt_o), 64'(0));
        chk("rst_rvalid", 64'(s_r_valid_o), 64'(0));
        chk("rst_mreq", 64'(m_req_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_gnt_edge", 64'(s_gnt_o), 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rand_fields();
        do_reset();

        // Two plugs requesting with single-cycle responses alternate.
        s_req_i = 4'b0011;
        m_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_fields();
            m_r_valid_i = (q_m.size() > 0);
            check_outputs();
            chk("alt_gnt", 64'(s_gnt_o), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) chk("alt_rvalid", 64'(s_r_valid_o), ((i - 1) % 2 == 0) ? 64'h1 : 64'h2);
            advance();
        end

        // Round-robin skip over non-requesting plugs.
        do_reset();
        s_req_i = 4'b1010;
        m_gnt_i = 1'b1;
        check_outputs();
        chk("rr_first", 64'(s_gnt_o), 64'h2);
        advance();
        check_outputs();
        chk("rr_second", 64'(s_gnt_o), 64'h8);
        advance();
        s_req_i = 4'b1111;
        check_outputs();
        chk("rr_wrap", 64'(s_gnt_o), 64'h1);
        advance();

        // Fill to depth, stall, then one response frees a slot.
        do_reset();
        s_req_i = 4'b0001;
        m_gnt_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check_outputs();
            chk("fill_gnt", 64'(s_gnt_o), 64'h1);
            advance();
        end
        check_outputs();
        chk("full_gnt", 64'(s_gnt_o), 64'h0);
        chk("full_mreq", 64'(m_req_o), 64'h0);
        chk("full_busy", 64'(busy_o), 64'h1);
        advance();
        m_r_valid_i = 1'b1;
        check_outputs();
        chk("full_pop_rvalid", 64'(s_r_valid_o), 64'h1);
        chk("full_pop_gnt", 64'(s_gnt_o), 64'h0);
        advance();
        m_r_valid_i = 1'b0;
        check_outputs();
        chk("resume_gnt", 64'(s_gnt_o), 64'h1);
        advance();

        // Interleaved grants with delayed in-order responses.
        do_reset();
        m_gnt_i = 1'b1;
        s_req_i = 4'b0100; check_outputs(); chk("il_g0", 64'(s_gnt_o), 64'h4); advance();
        s_req_i = 4'b0001; check_outputs(); chk("il_g1", 64'(s_gnt_o), 64'h1); advance();
        s_req_i = 4'b0100; check_outputs(); chk("il_g2", 64'(s_gnt_o), 64'h4); advance();
        s_req_i = 4'b0000;
        for (int i = 0; i < 3; i++) step();
        m_r_valid_i = 1'b1;
        check_outputs(); chk("il_r0", 64'(s_r_valid_o), 64'h4); advance();
        check_outputs(); chk("il_r1", 64'(s_r_valid_o), 64'h1); advance();
        check_outputs(); chk("il_r2", 64'(s_r_valid_o), 64'h4); chk("il_busy", 64'(busy_o), 64'h1); advance();
        m_r_valid_i = 1'b0;
        check_outputs(); chk("il_idle", 64'(busy_o), 64'h0); advance();

        // Response with nothing outstanding is dropped and latches the error.
        do_reset();
        m_r_valid_i = 1'b1;
        check_outputs();
        chk("orphan_rvalid", 64'(s_r_valid_o), 64'h0);
        advance();
        m_r_valid_i = 1'b0;
        check_outputs(); chk("orphan_err", 64'(err_o), 64'h1); advance();
        for (int i = 0; i < 3; i++) step();
        chk("orphan_err_sticky", 64'(err_o), 64'h1);
        do_reset();
        chk("orphan_err_clr", 64'(err_o), 64'h0);

        // Asynchronous reset with three transactions outstanding.
        s_req_i = 4'b0010;
        m_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        s_req_i = 4'b0000;
        check_outputs();
        chk("pre_rst_busy", 64'(busy_o), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy_o), 64'h0);
        chk("async_mreq", 64'(m_req_o), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_req_i = 4'b1111;
        check_outputs();
        chk("post_rst_rr", 64'(s_gnt_o), 64'h1);
        advance();
        s_req_i     = 4'b0000;
        m_r_valid_i = 1'b1;
        step();
        step();
        m_r_valid_i = 1'b0;
        check_outputs();
        chk("post_rst_orphan_err", 64'(err_o), 64'h1);
        advance();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            rand_fields();
            s_req_i     = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            m_gnt_i     = ($urandom_range(0, 3) != 0);
            m_r_valid_i = (q_m.size() > 0) ? ($urandom_range(0, 2) == 0)
                                           : ($urandom_range(0, 40) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
